// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle plus the data-memory port of mem_access_ctrl.
// The slave modport is the controller's view; master is the CPU/memory environment's view.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 10
) ();
  logic              req;
  logic              st;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_din;
  logic              dm_we;
  logic [31:0]       dm_dout;
  logic [31:0]       rdata;
  logic              done;
  logic              busy;
  logic              err;

  modport slave (
    input  req, st, op, addr, wdata, dm_dout,
    output dm_addr, dm_din, dm_we, rdata, done, busy, err
  );

  modport master (
    output req, st, op, addr, wdata, dm_dout,
    input  dm_addr, dm_din, dm_we, rdata, done, busy, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store controller in front of a byte-addressed little-endian word memory.
// Sub-word stores are done as read-modify-write on the aligned word; load results are registered.
module mem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_ctrl_if.slave   bus
);

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_LD, S_ST, S_RMW_RD, S_RMW_WR, S_ERR, S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        op_p0;
  logic [1:0]        off_p0;
  logic [15:0]       wdata_p0;
  logic [ADDR_W-1:0] dm_addr_r;
  logic [31:0]       dm_din_r;
  logic              dm_we_r;
  logic [31:0]       rdata_r;
  logic              done_r;
  logic              err_r;

  function automatic logic is_bad(input logic st, input logic [2:0] op, input logic [1:0] off);
    is_bad = 1'b1;
    case (op)
      OP_B:    is_bad = 1'b0;
      OP_H:    is_bad = off[0];
      OP_W:    is_bad = (off != 2'b00);
      OP_BU:   is_bad = st;
      OP_HU:   is_bad = st | off[0];
      default: is_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] op,
                                           input logic [1:0] off);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    b_s = word[{off, 3'b000} +: 8];
    h_s = word[{off[1], 4'b0000} +: 16];
    case (op)
      OP_B:    load_ext = 32'(b_s);
      OP_H:    load_ext = 32'(h_s);
      OP_BU:   load_ext = {24'h0, b_s};
      OP_HU:   load_ext = {16'h0, h_s};
      default: load_ext = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] wd,
                                        input logic half, input logic [1:0] off);
    merge = word;
    if (half) merge[{off[1], 4'b0000} +: 16] = wd;
    else      merge[{off, 3'b000} +: 8]      = wd[7:0];
  endfunction

  // Stage p0: request latched at accept; outputs to dm are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_p0     <= '0;
      off_p0    <= '0;
      wdata_p0  <= '0;
      dm_addr_r <= '0;
      dm_din_r  <= '0;
      dm_we_r   <= 1'b0;
      rdata_r   <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            op_p0     <= bus.op;
            off_p0    <= bus.addr[1:0];
            wdata_p0  <= bus.wdata[15:0];
            err_r     <= 1'b0;
            dm_addr_r <= {bus.addr[ADDR_W-1:2], 2'b00};
            if (is_bad(bus.st, bus.op, bus.addr[1:0])) begin
              state <= S_ERR;
            end else if (!bus.st) begin
              state <= S_LD;
            end else if (bus.op == OP_W) begin
              state    <= S_ST;
              dm_we_r  <= 1'b1;
              dm_din_r <= bus.wdata;
            end else begin
              state <= S_RMW_RD;
            end
          end
        end
        S_LD: begin
          rdata_r <= load_ext(bus.dm_dout, op_p0, off_p0);
          state   <= S_DONE;
          done_r  <= 1'b1;
        end
        S_RMW_RD: begin
          // dm_din doubles as the merge buffer for the write cycle
          dm_din_r <= merge(bus.dm_dout, wdata_p0, (op_p0 == OP_H), off_p0);
          dm_we_r  <= 1'b1;
          state    <= S_RMW_WR;
        end
        S_ST, S_RMW_WR: begin
          dm_we_r  <= 1'b0;
          dm_din_r <= '0;
          state    <= S_DONE;
          done_r   <= 1'b1;
        end
        S_ERR: begin
          err_r  <= 1'b1;
          state  <= S_DONE;
          done_r <= 1'b1;
        end
        S_DONE: begin
          dm_addr_r <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dm_addr = dm_addr_r;
  assign bus.dm_din  = dm_din_r;
  assign bus.dm_we   = dm_we_r;
  assign bus.rdata   = rdata_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign bus.busy    = (state != S_IDLE);

endmodule
